shift_reg_ctrl: RTL

Command-driven sequencer for the team's serial JK flip-flop shift register chain. It accepts one command at a time over a valid/ready handshake and drives the chain's serial input, shift enable and preset/clear strobes. Supported operations: clear the chain, preset it, shift in a serial pattern, or rotate it N steps. It sits between the test/top-level stimulus logic and the flip-flop chain, replacing hand-timed `#` delays with cycle-exact control.

---
 rtl/shift_reg_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a serial JK flip-flop shift register chain: clear, preset, shift-in, rotate.
// Define SR_JOHNSON_EN to make ROTATE feed back inverted (twisted ring).
module shift_reg_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_d,
    output logic             sr_en,
    output logic             sr_clear,
    output logic             sr_preset,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, STROBE, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {OP_CLEAR, OP_PRESET, OP_SHIFT, OP_ROTATE} op_e;

    state_e            state, state_n;
    op_e               op_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  data_r;
    logic              accept;
    logic              fb;
    logic              sr_q_unused;

    assign sr_q_unused = &{1'b0, sr_q[WIDTH-2:0]};
    assign cmd_ready   = (state == IDLE) && clear;
    assign accept      = cmd_valid && cmd_ready;

`ifdef SR_JOHNSON_EN
    assign fb = ~sr_q[WIDTH-1];
`else
    assign fb = sr_q[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (!clear) begin
            state  <= IDLE;
            op_r   <= OP_CLEAR;
            cnt_r  <= '0;
            data_r <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_r   <= op_e'(cmd_op);
                cnt_r  <= cmd_count;
                data_r <= cmd_data;
            end else if (state == SHIFT) begin
                // Guarded decrement: the counter holds at zero rather than wrapping.
                if (cnt_r != '0)
                    cnt_r <= cnt_r - CNT_W'(1);
                data_r <= data_r >> 1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!cmd_op[1])
                        state_n = STROBE;
                    else if (cmd_count == '0)
                        state_n = DONE;
                    else
                        state_n = SHIFT;
                end
            end
            STROBE: state_n = DONE;
            SHIFT: begin
                if (cnt_r <= CNT_W'(1))
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sr_en     = (state == SHIFT);
        sr_d      = 1'b0;
        sr_clear  = (state == STROBE) && (op_r == OP_CLEAR);
        sr_preset = (state == STROBE) && (op_r == OP_PRESET);
        busy      = (state != IDLE);
        done      = (state == DONE);
        if (sr_en)
            sr_d = (op_r == OP_ROTATE) ? fb : data_r[0];
    end

endmodule
